// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the serial sequence detectors.
// It sends one bit every DIV clocks and can reload gaplessly on the done cycle.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ser_q, ser_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               accept;

    assign done       = (state_q == SHIFT) && (div_cnt_q == DIV_LAST) && (bit_cnt_q == BIT_LAST);
    assign load_ready = (state_q == IDLE) || done;
    assign accept     = load_valid && load_ready;

    assign ser_out    = ser_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        ser_d     = ser_q;
        strobe_d  = strobe_q;
        busy_d    = busy_q;

        // An accept on the done cycle takes priority, giving a zero-gap reload.
        if (accept) begin
            state_d   = SHIFT;
            shift_d   = data_in;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            ser_d     = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
            strobe_d  = 1'b1;
            busy_d    = 1'b1;
        end else if (state_q == SHIFT) begin
            if (div_cnt_q != DIV_LAST) begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
                strobe_d  = 1'b0;
            end else if (bit_cnt_q != BIT_LAST) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shift_d   = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                             : {1'b0, shift_q[WIDTH-1:1]};
                ser_d     = (MSB_FIRST != 0) ? shift_q[WIDTH-2] : shift_q[1];
                strobe_d  = 1'b1;
            end else begin
                state_d   = IDLE;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                ser_d     = 1'b0;
                strobe_d  = 1'b0;
                busy_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            ser_q     <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ser_q     <= ser_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer with three instances (DIV=4 MSB-first, DIV=1 LSB-first, DIV=3 random).
// Expected streams come from word bits and bit indices; the random run uses a word scoreboard.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       lv0 = 1'b0, lv1 = 1'b0, lv2 = 1'b0;
    logic       lr0, so0, bs0, by0, dn0;
    logic       lr1, so1, bs1, by1, dn1;
    logic       lr2, so2, bs2, by2, dn2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u0 (
        .clk(clk), .resetn(resetn), .data_in(d0), .load_valid(lv0), .load_ready(lr0),
        .ser_out(so0), .bit_strobe(bs0), .busy(by0), .done(dn0));

    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .resetn(resetn), .data_in(d1), .load_valid(lv1), .load_ready(lr1),
        .ser_out(so1), .bit_strobe(bs1), .busy(by1), .done(dn1));

    bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u2 (
        .clk(clk), .resetn(resetn), .data_in(d2), .load_valid(lv2), .load_ready(lr2),
        .ser_out(so2), .bit_strobe(bs2), .busy(by2), .done(dn2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic wordBit(input logic [7:0] w, input int i, input bit msbFirst);
        return msbFirst ? w[7 - i] : w[i];
    endfunction

    // Walks u0 through one 32-cycle word starting at its first-bit cycle; optional mid-word pulse of 0xFF.
    task automatic runWord0(input logic [7:0] w, input string tag, input int pulseAt);
        for (int k = 1; k <= 32; k++) begin
            chk({tag, "_ser"},    32'(so0), 32'(wordBit(w, (k - 1) / 4, 1'b1)));
            chk({tag, "_strobe"}, 32'(bs0), 32'(((k - 1) % 4) == 0));
            chk({tag, "_done"},   32'(dn0), 32'(k == 32));
            chk({tag, "_ready"},  32'(lr0), 32'(k == 32));
            chk({tag, "_busy"},   32'(by0), 32'd1);
            if (pulseAt != 0 && k == pulseAt) begin
                lv0 = 1'b1;
                d0  = 8'hFF;
            end else if (pulseAt != 0 && k == pulseAt + 1) begin
                lv0 = 1'b0;
            end
            if (k < 32) tick();
        end
    endtask

    task automatic idle0(input string tag);
        tick();
        chk({tag, "_idle_ser"},    32'(so0), 32'd0);
        chk({tag, "_idle_busy"},   32'(by0), 32'd0);
        chk({tag, "_idle_ready"},  32'(lr0), 32'd1);
        chk({tag, "_idle_strobe"}, 32'(bs0), 32'd0);
        chk({tag, "_idle_done"},   32'(dn0), 32'd0);
    endtask

    initial begin
        logic [7:0] expQ[$];
        logic [7:0] recon;
        logic [7:0] expWord;
        int accepts, dones, words, nbits;
        bit pending;

        // Reset and check the idle/reset values on every instance.
        #12;
        chk("rst_ser0",    32'(so0), 32'd0);
        chk("rst_busy0",   32'(by0), 32'd0);
        chk("rst_strobe0", 32'(bs0), 32'd0);
        chk("rst_ready0",  32'(lr0), 32'd1);
        chk("rst_done0",   32'(dn0), 32'd0);
        chk("rst_ready1",  32'(lr1), 32'd1);
        chk("rst_ready2",  32'(lr2), 32'd1);
        resetn = 1'b1;
        tick();
        tick();
        chk("idle_hold_ser0", 32'(so0), 32'd0);

        // Single 0xA5 word, valid held for one cycle only.
        lv0 = 1'b1;
        d0  = 8'hA5;
        tick();
        lv0 = 1'b0;
        runWord0(8'hA5, "t1", 0);
        idle0("t1");

        // 0x03 then 0xC0 back to back with no idle cycle between them.
        lv0 = 1'b1;
        d0  = 8'h03;
        tick();
        d0  = 8'hC0;
        runWord0(8'h03, "t2a", 0);
        tick();
        lv0 = 1'b0;
        runWord0(8'hC0, "t2b", 0);
        idle0("t2");

        // 0x00 with a one-cycle 0xFF request during bit 3 that must be ignored.
        lv0 = 1'b1;
        d0  = 8'h00;
        tick();
        lv0 = 1'b0;
        runWord0(8'h00, "t3", 14);
        idle0("t3");

        // 0xFF aborted by an asynchronous reset during bit 5.
        lv0 = 1'b1;
        d0  = 8'hFF;
        tick();
        lv0 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            chk("t4_ser", 32'(so0), 32'd1);
            if (k < 22) tick();
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("t4_async_ser",    32'(so0), 32'd0);
        chk("t4_async_busy",   32'(by0), 32'd0);
        chk("t4_async_strobe", 32'(bs0), 32'd0);
        chk("t4_async_ready",  32'(lr0), 32'd1);
        #2;
        resetn = 1'b1;
        tick();
        chk("t4_no_resume_ser",  32'(so0), 32'd0);
        chk("t4_no_resume_busy", 32'(by0), 32'd0);
        lv0 = 1'b1;
        d0  = 8'h80;
        tick();
        lv0 = 1'b0;
        runWord0(8'h80, "t4", 0);
        idle0("t4");

        // LSB-first with DIV=1: one bit per cycle, strobe every cycle.
        lv1 = 1'b1;
        d1  = 8'h01;
        tick();
        lv1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("t5_ser",    32'(so1), 32'(wordBit(8'h01, k - 1, 1'b0)));
            chk("t5_strobe", 32'(bs1), 32'd1);
            chk("t5_done",   32'(dn1), 32'(k == 8));
            chk("t5_busy",   32'(by1), 32'd1);
            if (k < 8) tick();
        end
        tick();
        chk("t5_idle_ser",  32'(so1), 32'd0);
        chk("t5_idle_busy", 32'(by1), 32'd0);
        chk("t5_idle_strb", 32'(bs1), 32'd0);

        // Random traffic on the DIV=3 instance, words rebuilt from strobe samples.
        accepts = 0;
        dones   = 0;
        words   = 0;
        nbits   = 0;
        recon   = '0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            tick();
            if (bs2) begin
                recon = {recon[6:0], so2};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    words++;
                    if (expQ.size() == 0) begin
                        chk("t6_spurious_word", 32'(recon), 32'hFFFF_FFFF);
                    end else begin
                        expWord = expQ.pop_front();
                        chk("t6_word", 32'(recon), 32'(expWord));
                    end
                end
            end
            if (dn2) dones++;
            if (!by2 && !lv2 && accepts >= 1000) break;
            if (!pending) begin
                if (accepts < 1000 && $urandom_range(0, 2) != 0) begin
                    lv2 = 1'b1;
                    d2  = 8'($urandom);
                end else begin
                    lv2 = 1'b0;
                end
            end
            if (lv2 && lr2) begin
                expQ.push_back(d2);
                accepts++;
                pending = 1'b0;
            end else begin
                pending = lv2;
            end
        end
        chk("t6_accepts",      32'(accepts), 32'd1000);
        chk("t6_done_pulses",  32'(dones), 32'(accepts));
        chk("t6_words_seen",   32'(words), 32'(accepts));
        chk("t6_queue_empty",  32'(expQ.size()), 32'd0);
        chk("t6_final_busy",   32'(by2), 32'd0);
        chk("t6_final_ser",    32'(so2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence-detector FSMs. It produces their single-bit `in` stream.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per DIV clocks. It marks each new bit with a strobe.
- Gapless back-to-back words are supported, so downstream detectors see a continuous stream across word boundaries.
- The serial line idles at 0, so no false "1" runs reach the detector.

Parameters:
- WIDTH, 8, bits per word; must be >= 2.
- DIV, 4, clock cycles each bit is held on ser_out; must be >= 1.
- MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to serialize; sampled only on the accept edge.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream, registered; this is the detector's `in`.
- bit_strobe  output  1  high for the first clock of each bit period.
- busy  output  1  a word is being shifted.
- done  output  1  high during the last clock of the last bit period of a word.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, ser_out=0, bit_strobe=0, busy=0.
  - Counters and shift register = 0. done=0 and load_ready=1 (decoded from IDLE).
  - A reset asserted mid-word aborts the word immediately; ser_out drops to 0 without waiting for a clock. The aborted word is not resumed.
- State machine: two states, IDLE and SHIFT, in a 1-bit state register.
- Internal counters:
  - div_cnt counts 0..DIV-1; width is clog2(DIV), minimum 1 bit.
  - bit_cnt counts 0..WIDTH-1; width is clog2(WIDTH).
- Combinational decodes (from registers only, no input-to-output paths):
  - done = (state==SHIFT) && div_cnt==DIV-1 && bit_cnt==WIDTH-1.
  - load_ready = (state==IDLE) || done.
- Accept: a rising edge where load_valid && load_ready. On that edge:
  - shift register <= data_in; state <= SHIFT; busy <= 1.
  - div_cnt <= 0; bit_cnt <= 0.
  - ser_out <= first bit (per MSB_FIRST); bit_strobe <= 1.
  - Latency: the first bit is visible in the cycle after the accept edge.
- In SHIFT, on every edge not covered by an accept:
  - If div_cnt < DIV-1: div_cnt increments; bit_strobe <= 0; ser_out holds.
  - If div_cnt == DIV-1 and bit_cnt < WIDTH-1: div_cnt <= 0; bit_cnt increments; ser_out <= next bit; bit_strobe <= 1.
  - If done and load_valid: this is an accept (gapless reload). The new word's first bit follows the previous word's last bit with zero idle cycles.
  - If done and no load_valid: state <= IDLE; ser_out <= 0; busy <= 0; bit_strobe <= 0.
- In IDLE without an accept, all registered outputs hold at their reset values.
- Word duration: exactly WIDTH*DIV cycles from the first-bit cycle to the last done cycle.
- load_valid while load_ready=0 (mid-word) is ignored. Upstream must hold load_valid and data_in until accepted; no drop, no buffering.
- DIV=1 behaviour: bit_strobe is high every SHIFT cycle. done is high only on the final bit's cycle.
- Shift direction: with MSB_FIRST=1 the register shifts left and ser_out takes the top bit. With MSB_FIRST=0 it shifts right and ser_out takes bit 0.

Test Plan:
1. Reset with WIDTH=8, DIV=4, MSB_FIRST=1, then load 0xA5 with load_valid for one cycle.
   - ser_out = 1,0,1,0,0,1,0,1, each held 4 cycles.
   - 8 bit_strobe pulses; done high in cycle 32 after the accept edge.
   - Then ser_out=0, busy=0, load_ready=1.
2. Load 0x03, hold load_valid with 0xC0 queued behind it.
   - 0xC0 is accepted on the done edge; zero-gap stream 0,0,0,0,0,0,1,1,1,1,0,0,0,0,0,0.
   - A downstream detector sees one 4-bit run of 1s spanning the word boundary.
3. Pulse load_valid with 0xFF at bit 3 of a 0x00 word.
   - load_ready=0, request ignored; ser_out stays 0 for all 32 cycles.
   - 0xFF is sent only if load_valid is still held at done.
4. Assert resetn=0 between edges during bit 5 of 0xFF.
   - ser_out, busy and bit_strobe are 0 before the next clock edge.
   - After release, loading 0x80 starts cleanly with ser_out=1 for 4 cycles, then seven 0 bits.
5. MSB_FIRST=0, DIV=1, load 0x01.
   - ser_out = 1 then seven 0s on consecutive cycles; bit_strobe high all 8 cycles.
   - done in the 8th cycle, then IDLE.
6. Random load_valid/data_in over 1000 words, DIV=3.
   - A scoreboard reconstructs each word from bit_strobe samples and matches every accepted word.
   - The number of accepts equals the number of done pulses.
